// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and default sizes for mem_port_arbiter
//
// Purpose: arbiter FSM state enum, requester grant enum, default widths and
//          the default memory-wait timeout.
// Ports:   none (package).

package pipeline_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signal bundle for mem_port_arbiter
//
// Purpose: groups the fetch port, data port, shared memory port and status
//          signals of the arbiter.
// Ports:   slave  - arbiter view (requests/memory responses in, acks/memory
//                   requests out)
//          master - environment view (the opposite directions)

interface mem_port_arbiter_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              err;
  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ack, if_rdata, d_ack, d_rdata, err, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ack, if_rdata, d_ack, d_rdata, err, stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin selector between fetch and data
//
// Purpose: picks the single pending requester, or on contention the one that
//          was not granted last.
// Ports:   i_req_f      fetch request
//          i_req_d      data request
//          i_last_grant requester granted most recently
//          o_grant      one-hot grant, bit0 = fetch, bit1 = data

module rr_arbiter2
  import pipeline_pkg::*;
(
  input  logic       i_req_f,
  input  logic       i_req_d,
  input  grant_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req_f && i_req_d) begin
      o_grant = (i_last_grant == FETCH) ? 2'b10 : 2'b01;
    end else if (i_req_d) begin
      o_grant = 2'b10;
    end else if (i_req_f) begin
      o_grant = 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between a fetch and a data requester
//
// Purpose: IDLE/BUSY/RESP arbiter. IDLE samples requests and launches a
//          registered memory access, BUSY waits for mem_ack (bounded by
//          TIMEOUT), RESP pulses the winner's ack for one cycle.
// Ports:   clk   - clock, rising edge
//          rst_n - asynchronous active-low reset
//          bus   - mem_port_arbiter_if.slave: fetch port (if_*), data port
//                  (d_*), memory port (mem_*), err and stall

module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_e            r_state;
  state_e            w_next_state;
  grant_e            r_grant;
  grant_e            r_last_grant;
  logic [7:0]        r_wait_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_grant;
  logic              w_sel_data;
  logic              w_start;
  logic              w_complete;
  logic              w_timeout;
  logic              w_if_ack;
  logic              w_d_ack;

  rr_arbiter2 u_rr (
    .i_req_f      (bus.if_req),
    .i_req_d      (bus.d_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_sel_data = (w_grant == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // mem_ack takes priority over the timeout check so a response landing in
  // the last allowed cycle is still delivered as good data.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          w_complete   = 1'b1;
          w_next_state = RESP;
        end else if (r_wait_cnt == TIMEOUT_M1) begin
          w_timeout    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // A timed-out access still counts as a grant, so a dead target cannot let
  // one requester starve the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= FETCH;
      r_last_grant <= FETCH;
      r_wait_cnt   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else if (w_start) begin
      r_grant     <= w_sel_data ? DATA : FETCH;
      r_wait_cnt  <= '0;
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_sel_data & bus.d_we;
      r_mem_addr  <= w_sel_data ? (bus.d_addr >> 2) : (bus.if_addr >> 2);
      r_mem_wdata <= w_sel_data ? bus.d_wdata : '0;
    end else if (w_complete) begin
      r_mem_req    <= 1'b0;
      r_rdata      <= r_mem_we ? '0 : bus.mem_rdata;
      r_err        <= 1'b0;
      r_last_grant <= r_grant;
    end else if (w_timeout) begin
      r_mem_req    <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b1;
      r_last_grant <= r_grant;
    end else if (r_state == BUSY) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_if_ack = (r_state == RESP) && (r_grant == FETCH);
  assign w_d_ack  = (r_state == RESP) && (r_grant == DATA);

  assign bus.if_ack    = w_if_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.if_rdata  = r_rdata;
  assign bus.d_rdata   = r_rdata;
  assign bus.err       = (r_state == RESP) && r_err;
  assign bus.stall     = (bus.if_req && !w_if_ack) || (bus.d_req && !w_d_ack);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_mem_req",  bus.mem_req,  0);
    chk("rst_mem_we",   bus.mem_we,   0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wd",   bus.mem_wdata, 0);
    chk("rst_if_ack",   bus.if_ack,   0);
    chk("rst_d_ack",    bus.d_ack,    0);
    chk("rst_err",      bus.err,      0);
    chk("rst_rdata",    bus.if_rdata, 0);
    rst_n = 1'b1;

    // single fetch, zero-wait memory
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    chk("f1_stall_wait", bus.stall, 1);
    tick();
    chk("f1_mem_req",  bus.mem_req,  1);
    chk("f1_mem_addr", bus.mem_addr, 32'h4);
    chk("f1_mem_we",   bus.mem_we,   0);
    chk("f1_if_ack_early", bus.if_ack, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE0001;
    tick();
    chk("f1_if_ack",   bus.if_ack,   1);
    chk("f1_d_ack",    bus.d_ack,    0);
    chk("f1_rdata",    bus.if_rdata, 32'hCAFE0001);
    chk("f1_err",      bus.err,      0);
    chk("f1_mem_req0", bus.mem_req,  0);
    chk("f1_stall_ack", bus.stall,   0);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
    chk("f1_if_ack_end", bus.if_ack, 0);

    // contention from reset: D,F,D,F while both are held
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h40;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_mem_req",  bus.mem_req,  1);
      chk("rr_mem_addr", bus.mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h100 + k;
      tick();
      bus.mem_ack = 1'b0;
      chk("rr_d_ack",  bus.d_ack,  (k % 2 == 0) ? 1 : 0);
      chk("rr_if_ack", bus.if_ack, (k % 2 == 0) ? 0 : 1);
      chk("rr_rdata",  bus.d_rdata, 32'h100 + k);
      tick();
      chk("rr_idle_ack", bus.d_ack | bus.if_ack, 0);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    tick();

    // store: registered outputs, stable while waiting, rdata forced to 0
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'hDEADBEEF;
    tick();
    chk("st_mem_req",  bus.mem_req,   1);
    chk("st_mem_we",   bus.mem_we,    1);
    chk("st_mem_addr", bus.mem_addr,  32'h8);
    chk("st_mem_wd",   bus.mem_wdata, 32'hDEADBEEF);
    tick();
    chk("st_hold_req",  bus.mem_req,  1);
    chk("st_hold_addr", bus.mem_addr, 32'h8);
    chk("st_no_ack",    bus.d_ack,    0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    chk("st_d_ack",  bus.d_ack,   1);
    chk("st_rdata",  bus.d_rdata, 0);
    chk("st_if_ack", bus.if_ack,  0);
    chk("st_err",    bus.err,     0);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    tick();

    // timeout: mem_req high for TO cycles, then err ack with zero data
    bus.mem_rdata = 32'hFFFFFFFF;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h44;
    tick();
    chk("to_mem_req0", bus.mem_req, 1);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("to_mem_req_hold", bus.mem_req, 1);
      chk("to_no_ack", bus.if_ack, 0);
    end
    tick();
    chk("to_mem_req_drop", bus.mem_req,  0);
    chk("to_if_ack",       bus.if_ack,   1);
    chk("to_err",          bus.err,      1);
    chk("to_rdata",        bus.if_rdata, 0);
    bus.if_req = 1'b0;
    tick();
    chk("to_err_clear", bus.err,    0);
    chk("to_ack_clear", bus.if_ack, 0);

    // mem_ack lands in the timeout cycle: data wins, no err
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h30;
    tick();
    for (int k = 1; k < TO; k++) tick();
    chk("tc_mem_req", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    tick();
    chk("tc_d_ack", bus.d_ack,   1);
    chk("tc_err",   bus.err,     0);
    chk("tc_rdata", bus.d_rdata, 32'hA5A5A5A5);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();

    // spurious mem_ack in IDLE
    bus.mem_ack = 1'b1;
    tick();
    tick();
    chk("sp_if_ack",  bus.if_ack,  0);
    chk("sp_d_ack",   bus.d_ack,   0);
    chk("sp_mem_req", bus.mem_req, 0);
    chk("sp_err",     bus.err,     0);
    bus.mem_ack = 1'b0;
    tick();

    // reset during BUSY abandons the access; reissue completes
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8;
    tick();
    chk("rb_mem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rb_mem_req_async", bus.mem_req, 0);
    tick();
    chk("rb_no_ack",   bus.if_ack,  0);
    chk("rb_req_low",  bus.mem_req, 0);
    rst_n = 1'b1;
    tick();
    chk("rb_reissue_req",  bus.mem_req,  1);
    chk("rb_reissue_addr", bus.mem_addr, 32'h2);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    tick();
    chk("rb_if_ack", bus.if_ack,   1);
    chk("rb_rdata",  bus.if_rdata, 32'h77);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
    chk("rb_done", bus.if_ack, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width for both requesters.
REQ-002 Parameter: DATA_W, default 32, data width.
REQ-003 Parameter: TIMEOUT, default 16, maximum memory wait in cycles; legal range 2..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 if_req  in  1  fetch request; held until if_ack.
REQ-008 if_addr  in  ADDR_W  fetch byte address.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 if_rdata  out  DATA_W  fetch data; valid while if_ack=1.
REQ-011 d_req  in  1  data request; held until d_ack.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data byte address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 d_rdata  out  DATA_W  load data; valid while d_ack=1.
REQ-017 err  out  1  timeout flag; valid with the same-cycle ack.
REQ-018 mem_req  out  1  memory request, registered.
REQ-019 mem_we  out  1  memory write enable, registered.
REQ-020 mem_addr  out  ADDR_W  memory word address, registered.
REQ-021 mem_wdata  out  DATA_W  memory write data, registered.
REQ-022 mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
REQ-023 mem_ack  in  1  memory completion; single-cycle.
REQ-024 stall  out  1  combinational; 1 whenever if_req or d_req is high and its ack is not high in the same cycle.

Function
REQ-025 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-026 IDLE with at least one request pending: the block SHALL select a winner, register the winner's address, data and direction, set mem_req=1, and go to BUSY.
REQ-027 Arbitration with a single request pending: that request SHALL win.
REQ-028 Arbitration with both requests pending: the requester not granted last time SHALL win (round-robin via a last_grant flag).
REQ-029 mem_addr SHALL equal the byte address shifted right by 2; address bits [1:0] are ignored.
REQ-030 BUSY: mem_req and all mem_* outputs SHALL hold stable until mem_ack=1 is sampled.
REQ-031 On mem_ack=1 in BUSY: the block SHALL capture mem_rdata (0 for stores), drop mem_req, go to RESP, and update last_grant.
REQ-032 RESP: the block SHALL pulse the winner's ack for exactly one cycle with the captured data and err, then go to IDLE.
REQ-033 Requests SHALL NOT be sampled in BUSY or RESP; a request still high in IDLE is treated as a new request.
REQ-034 Latency: request sampled at edge N gives mem_req=1 after N. A zero-wait mem_ack gives ack in cycle N+2. Back-to-back throughput is one access per 3 cycles.
REQ-035 A wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_ack.
REQ-036 Timeout: when the counter reaches TIMEOUT-1 without mem_ack, the block SHALL drop mem_req and go to RESP with err=1 and data=0.
REQ-037 If mem_ack arrives in the same cycle as the timeout, mem_ack SHALL win (err=0).
REQ-038 mem_ack in IDLE or RESP SHALL be ignored with no state change.
REQ-039 if_ack and d_ack SHALL never both be 1 in the same cycle.
REQ-040 err SHALL be 0 whenever no ack is asserted.

Reset
REQ-041 rst_n=0 SHALL immediately force: state=IDLE; mem_req, mem_we, if_ack, d_ack, err = 0; mem_addr, mem_wdata, if_rdata, d_rdata, wait counter = 0; last_grant = FETCH (data wins the first contention).
REQ-042 Reset asserted mid-BUSY SHALL abandon the access with no ack; the requester re-issues after release.
REQ-043 The first request SHALL be sampled on the first rising edge after reset deassertion.

Structure
REQ-044 Package pipeline_pkg SHALL hold: the state enum (IDLE/BUSY/RESP), the grant enum (FETCH/DATA), and default widths and TIMEOUT.
REQ-045 Round-robin selection SHALL be one sub-module, rr_arbiter2 (two requests and a last_grant input; one-hot grant output).

Verification
REQ-046 Scenario: if_req only, if_addr=0x10, mem_ack one cycle after mem_req -> mem_addr=0x4, if_ack at N+2, if_rdata=mem_rdata.
REQ-047 Scenario: if_req and d_req both high from reset -> data served first, then fetch. Both held continuously -> grants alternate D,F,D,F.
REQ-048 Scenario: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x8, mem_wdata=0xDEADBEEF, d_ack with d_rdata=0.
REQ-049 Scenario: TIMEOUT=4, mem_ack never asserted -> mem_req drops after 4 cycles, ack with err=1 and data=0.
REQ-050 Scenario: mem_ack in the exact timeout cycle -> err=0, data captured. Spurious mem_ack in IDLE -> no ack.
REQ-051 Scenario: rst_n low during BUSY -> mem_req=0 immediately and no ack. After release, the re-issued request completes normally.
